// File: rtl/sram_axi_slave.sv
// sram_axi_slave
//
// AXI-Lite responder that converts single-beat reads and writes into
// asynchronous SRAM pin cycles. Only one transaction is in flight at a time,
// and there are no bursts. Pin timing is fixed: a write takes one strobe cycle
// plus one hold cycle, and a read holds oe_n low for READ_WAIT cycles.
//
// Parameters:
//   ADDR_BITS  SRAM word address width; AXI addresses are word addresses
//   DATA_BITS  SRAM / AXI data width
//   READ_WAIT  cycles oe_n is held low before read data is sampled (1-15)
//
// Ports:
//   clk, reset         system clock; asynchronous active-high reset
//   s_axi_aw*/w*/b*    AXI-Lite write address, write data and write response
//   s_axi_ar*/r*       AXI-Lite read address and read data
//   sram_io_addr       SRAM address pins
//   sram_io_data       SRAM data pins; driven only while writing
//   sram_io_we_n/oe_n/ce_n  SRAM strobes, active low
//
// Optional feature (macro SRAM_AXI_SLAVE_STATS_EN):
//   stat_wr_count / stat_rd_count are saturating 16-bit counts of completed
//   B and R handshakes.

module sram_axi_slave #(
    parameter int ADDR_BITS = 20,
    parameter int DATA_BITS = 16,
    parameter int READ_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] s_axi_awaddr,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    input  logic [DATA_BITS-1:0] s_axi_wdata,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    input  logic [ADDR_BITS-1:0] s_axi_araddr,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    output logic [DATA_BITS-1:0] s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready,
    output logic [ADDR_BITS-1:0] sram_io_addr,
    inout  wire  [DATA_BITS-1:0] sram_io_data,
    output logic                 sram_io_we_n,
    output logic                 sram_io_oe_n,
    output logic                 sram_io_ce_n
`ifdef SRAM_AXI_SLAVE_STATS_EN
    ,
    output logic [15:0]          stat_wr_count,
    output logic [15:0]          stat_rd_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_HOLD,
        BRESP,
        RD,
        RRESP
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(READ_WAIT - 1);

    state_t               state;
    logic                 rr_read;    // 1: a read wins the next simultaneous request
    logic [3:0]           wait_cnt;
    logic [DATA_BITS-1:0] wdata_q;
    logic                 drive_en;

    logic wr_ok;
    logic rd_ok;

    // A write is only eligible once both address and data are offered, so AW
    // is never accepted on its own.
    assign wr_ok = s_axi_awvalid && s_axi_wvalid;
    assign rd_ok = s_axi_arvalid;

    assign s_axi_bresp  = 2'b00;
    assign s_axi_rresp  = 2'b00;
    assign sram_io_data = drive_en ? wdata_q : {DATA_BITS{1'bz}};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values no matter how the statements are ordered.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every register, including the datapath ones, is reset; a reset
        // mid-transaction must leave the pins and responses in a known state.
        if (reset) begin
            state         <= IDLE;
            rr_read       <= 1'b1;
            wait_cnt      <= '0;
            wdata_q       <= '0;
            drive_en      <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            sram_io_addr  <= '0;
            sram_io_we_n  <= 1'b1;
            sram_io_oe_n  <= 1'b1;
            sram_io_ce_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axi_awready) begin
                        // Handshake cycle for the write offered last cycle.
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        if (wr_ok) begin
                            sram_io_addr <= s_axi_awaddr;
                            wdata_q      <= s_axi_wdata;
                            drive_en     <= 1'b1;
                            sram_io_ce_n <= 1'b0;
                            sram_io_we_n <= 1'b0;
                            state        <= WR;
                        end
                    end else if (s_axi_arready) begin
                        s_axi_arready <= 1'b0;
                        if (rd_ok) begin
                            sram_io_addr <= s_axi_araddr;
                            sram_io_ce_n <= 1'b0;
                            sram_io_oe_n <= 1'b0;
                            wait_cnt     <= '0;
                            state        <= RD;
                        end
                    end else if (wr_ok && (!rd_ok || !rr_read)) begin
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        // The pointer only moves when both types competed.
                        if (rd_ok) rr_read <= 1'b1;
                    end else if (rd_ok) begin
                        s_axi_arready <= 1'b1;
                        if (wr_ok) rr_read <= 1'b0;
                    end
                end
                WR: begin
                    sram_io_we_n <= 1'b1;
                    state        <= WR_HOLD;
                end
                WR_HOLD: begin
                    // Data was held one cycle past the we_n rising edge.
                    drive_en     <= 1'b0;
                    sram_io_ce_n <= 1'b1;
                    s_axi_bvalid <= 1'b1;
                    state        <= BRESP;
                end
                BRESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                RD: begin
                    if (wait_cnt == LAST_WAIT) begin
                        s_axi_rdata  <= sram_io_data;
                        sram_io_oe_n <= 1'b1;
                        sram_io_ce_n <= 1'b1;
                        s_axi_rvalid <= 1'b1;
                        state        <= RRESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RRESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SRAM_AXI_SLAVE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_wr_count <= '0;
            stat_rd_count <= '0;
        end else begin
            if (s_axi_bvalid && s_axi_bready && stat_wr_count != 16'hFFFF)
                stat_wr_count <= stat_wr_count + 16'd1;
            if (s_axi_rvalid && s_axi_rready && stat_rd_count != 16'hFFFF)
                stat_rd_count <= stat_rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_axi_slave.sv
// tb_sram_axi_slave
//
// Bench for sram_axi_slave with a small behavioural async SRAM on the pins.
// A per-cycle compare process predicts every output from a transaction
// timeline (cycles elapsed since the accepting handshake) and a reference
// memory updated at write acceptance. Directed sequences plus randomized
// traffic drive it; a few literal expectations pin the model itself.

`timescale 1ns/1ps

module tb_sram_axi_slave;

    localparam int A   = 4;
    localparam int D   = 8;
    localparam int RW  = 3;
    localparam int TMO = 200;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [A-1:0] s_axi_awaddr;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [D-1:0] s_axi_wdata;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready;
    logic [A-1:0] s_axi_araddr;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [D-1:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready;
    logic [A-1:0] sram_io_addr;
    wire  [D-1:0] sram_io_data;
    logic         sram_io_we_n;
    logic         sram_io_oe_n;
    logic         sram_io_ce_n;
`ifdef SRAM_AXI_SLAVE_STATS_EN
    logic [15:0]  stat_wr_count;
    logic [15:0]  stat_rd_count;
`endif

    sram_axi_slave #(.ADDR_BITS(A), .DATA_BITS(D), .READ_WAIT(RW)) dut (
        .clk(clk), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .sram_io_addr(sram_io_addr), .sram_io_data(sram_io_data), .sram_io_we_n(sram_io_we_n),
        .sram_io_oe_n(sram_io_oe_n), .sram_io_ce_n(sram_io_ce_n)
`ifdef SRAM_AXI_SLAVE_STATS_EN
        , .stat_wr_count(stat_wr_count), .stat_rd_count(stat_rd_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural async SRAM: drives while selected and output-enabled,
    // stores while selected and write-enabled.
    logic [D-1:0] sram_mem [16];
    assign sram_io_data = (!sram_io_ce_n && !sram_io_oe_n && sram_io_we_n)
                          ? sram_mem[sram_io_addr] : {D{1'bz}};
    always @(posedge clk)
        if (!sram_io_ce_n && !sram_io_we_n) sram_mem[sram_io_addr] <= sram_io_data;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [D-1:0] sweep_val(input logic [A-1:0] a);
        return {a, 2'b00, a[1:0] ^ 2'b01};
    endfunction

    // ---------------- reference model ----------------
    // Phase of the single transaction slot: nothing, a ready offer pulse,
    // or a write/read whose age counts cycles since its handshake.
    typedef enum {K_IDLE, K_OFFER_W, K_OFFER_R, K_WRITE, K_READ} phase_t;

    phase_t       kind = K_IDLE;
    int           age = 0;
    bit           rr_read = 1'b1;
    logic [A-1:0] t_addr;
    logic [D-1:0] t_data;
    logic [D-1:0] ref_mem [16];
    byte          grants [$];
    int           b_hs = 0;
    int           r_hs = 0;

    always @(negedge clk) begin
        bit wr_pins, rd_pins, exp_b, exp_r, w_ok, r_ok;
        if (reset) begin
            check("rst_awready", s_axi_awready, 0);
            check("rst_wready", s_axi_wready, 0);
            check("rst_arready", s_axi_arready, 0);
            check("rst_bvalid", s_axi_bvalid, 0);
            check("rst_rvalid", s_axi_rvalid, 0);
            check("rst_strobes", {sram_io_ce_n, sram_io_oe_n, sram_io_we_n}, 3'b111);
            check("rst_addr", sram_io_addr, 0);
            check("rst_rdata", s_axi_rdata, 0);
            kind = K_IDLE; age = 0; rr_read = 1'b1; b_hs = 0; r_hs = 0;
        end else begin
            wr_pins = (kind == K_WRITE) && (age == 1 || age == 2);
            rd_pins = (kind == K_READ) && (age >= 1) && (age <= RW);
            exp_b   = (kind == K_WRITE) && (age >= 3);
            exp_r   = (kind == K_READ) && (age >= RW + 1);
            check("awready", s_axi_awready, kind == K_OFFER_W);
            check("wready", s_axi_wready, kind == K_OFFER_W);
            check("arready", s_axi_arready, kind == K_OFFER_R);
            check("bvalid", s_axi_bvalid, exp_b);
            check("rvalid", s_axi_rvalid, exp_r);
            check("ce_n", sram_io_ce_n, !(wr_pins || rd_pins));
            check("we_n", sram_io_we_n, !(kind == K_WRITE && age == 1));
            check("oe_n", sram_io_oe_n, !rd_pins);
            if (wr_pins || rd_pins) begin
                check("pin_addr", sram_io_addr, t_addr);
                check("data_bus", sram_io_data, t_data);
            end
            if (exp_b) check("bresp", s_axi_bresp, 0);
            if (exp_r) begin
                check("rdata", s_axi_rdata, t_data);
                check("rresp", s_axi_rresp, 0);
            end
            case (kind)
                K_IDLE: begin
                    w_ok = s_axi_awvalid && s_axi_wvalid;
                    r_ok = s_axi_arvalid;
                    if (w_ok && r_ok) begin
                        kind = rr_read ? K_OFFER_R : K_OFFER_W;
                        rr_read = !rr_read;
                    end else if (w_ok) kind = K_OFFER_W;
                    else if (r_ok) kind = K_OFFER_R;
                    if (kind == K_OFFER_W) grants.push_back("W");
                    if (kind == K_OFFER_R) grants.push_back("R");
                end
                K_OFFER_W: begin
                    t_addr = s_axi_awaddr; t_data = s_axi_wdata;
                    ref_mem[s_axi_awaddr] = s_axi_wdata;
                    kind = K_WRITE; age = 1;
                end
                K_OFFER_R: begin
                    t_addr = s_axi_araddr; t_data = ref_mem[s_axi_araddr];
                    kind = K_READ; age = 1;
                end
                K_WRITE: if (exp_b && s_axi_bready) begin kind = K_IDLE; b_hs++; end else age++;
                K_READ:  if (exp_r && s_axi_rready) begin kind = K_IDLE; r_hs++; end else age++;
                default: kind = K_IDLE;
            endcase
        end
    end

    // ---------------- response-ready driver ----------------
    int b_stall = 0;
    int r_stall = 0;

    initial begin
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (s_axi_bvalid && b_stall > 0) begin s_axi_bready = 1'b0; b_stall--; end
            else s_axi_bready = ($urandom_range(0, 3) != 0);
            if (s_axi_rvalid && r_stall > 0) begin s_axi_rready = 1'b0; r_stall--; end
            else s_axi_rready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- master tasks ----------------
    task automatic wait_b(output int lat, output int bcyc);
        int n;
        n = 0; lat = 0; bcyc = 0;
        do begin
            @(negedge clk); n++;
            if (s_axi_bvalid) begin bcyc++; if (lat == 0) lat = n; end
        end while (!(s_axi_bvalid && s_axi_bready) && n < TMO);
        check("b_handshake_seen", s_axi_bvalid && s_axi_bready, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [A-1:0] a, input logic [D-1:0] d,
                            output int lat, output int bcyc);
        int n;
        s_axi_awaddr = a; s_axi_wdata = d;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(s_axi_awready && s_axi_wready) && n < TMO);
        check("aw_w_accept_seen", s_axi_awready && s_axi_wready, 1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        wait_b(lat, bcyc);
    endtask

    // Returns early, without a response, if reset is asserted meanwhile.
    task automatic do_read(input logic [A-1:0] a, output logic [D-1:0] rd,
                           output int lat, output int rcyc);
        int n;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        rd = '0; lat = 0; rcyc = 0; n = 0;
        do begin @(negedge clk); n++; end
        while (!s_axi_arready && n < TMO && !reset);
        check("ar_accept_seen", s_axi_arready || reset, 1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        if (!reset) begin
            n = 0;
            do begin
                @(negedge clk); n++;
                if (s_axi_rvalid) begin rcyc++; if (lat == 0) lat = n; end
            end while (!(s_axi_rvalid && s_axi_rready) && n < TMO && !reset);
            check("r_handshake_seen", (s_axi_rvalid && s_axi_rready) || reset, 1);
            rd = s_axi_rdata;
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int           lat_w, bc_w, lat_r, rc_r, n_main, seen;
    logic [D-1:0] rd_r;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin sram_mem[i] = '0; ref_mem[i] = '0; end
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wvalid = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Write then read back one location; latencies pinned by hand.
        do_write(4'h3, 8'h02, lat_w, bc_w);
        check("wr_latency", lat_w, 3);
        do_read(4'h3, rd_r, lat_r, rc_r);
        check("rd_latency", lat_r, RW + 1);
        check("rd_data_a3", rd_r, 8'h02);

        // Full sweep.
        for (int a = 0; a < 16; a++) do_write(4'(a), sweep_val(4'(a)), lat_w, bc_w);
        for (int a = 0; a < 16; a++) begin
            do_read(4'(a), rd_r, lat_r, rc_r);
            check("sweep_rd", rd_r, sweep_val(4'(a)));
        end
        check("sweep_rd_a9_literal", ref_mem[9], 8'h90);

        // Simultaneous requests right after reset: grants alternate from read.
        apply_reset();
        grants.delete();
        fork
            begin
                for (int k = 0; k < 2; k++) do_read(4'(7 + k), rd_r, lat_r, rc_r);
            end
            begin
                for (int k = 0; k < 2; k++) do_write(4'(11 + k), 8'hC0 + 8'(k), lat_w, bc_w);
            end
        join
        check("grant_count", grants.size(), 4);
        if (grants.size() == 4) begin
            check("grant0", grants[0], "R");
            check("grant1", grants[1], "W");
            check("grant2", grants[2], "R");
            check("grant3", grants[3], "W");
        end

        // Response backpressure with another request waiting.
        b_stall = 5;
        r_stall = 5;
        fork
            do_write(4'h4, 8'hA5, lat_w, bc_w);
            begin
                repeat (2) @(posedge clk);
                #1 do_read(4'h6, rd_r, lat_r, rc_r);
            end
        join
        check("b_stall_cycles", bc_w >= 6, 1);
        check("r_stall_cycles", rc_r >= 6, 1);
        check("rd_after_stall", rd_r, sweep_val(4'h6));

        // AW without W is never accepted.
        s_axi_awaddr = 4'hE; s_axi_wdata = 8'h3C; s_axi_awvalid = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (s_axi_awready || s_axi_wready) seen++;
        end
        check("aw_without_w_ready", seen, 0);
        @(posedge clk); #1 s_axi_wvalid = 1'b1;
        n_main = 0;
        do begin @(negedge clk); n_main++; end
        while (!(s_axi_awready || s_axi_wready) && n_main < TMO);
        check("aw_w_together", {s_axi_awready, s_axi_wready}, 2'b11);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        wait_b(lat_w, bc_w);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            logic [A-1:0] a1, a2;
            logic [D-1:0] d1;
            int op, gap;
            a1 = 4'($urandom); a2 = 4'($urandom); d1 = 8'($urandom);
            op = $urandom_range(0, 2);
            case (op)
                0: do_write(a1, d1, lat_w, bc_w);
                1: do_read(a2, rd_r, lat_r, rc_r);
                default: fork
                    do_write(a1, d1, lat_w, bc_w);
                    do_read(a2, rd_r, lat_r, rc_r);
                join
            endcase
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end

        // Reset in the middle of a read, then a fresh read.
        do_write(4'h5, 8'h5C, lat_w, bc_w);
        fork
            do_read(4'h5, rd_r, lat_r, rc_r);
            begin
                n_main = 0;
                do begin @(negedge clk); n_main++; end
                while (sram_io_oe_n && n_main < TMO);
                check("rd_phase_reached", sram_io_oe_n, 0);
                #2 reset = 1'b1;
                @(negedge clk);
                check("rst_mid_rd_oe_n", sram_io_oe_n, 1);
                check("rst_mid_rd_ce_n", sram_io_ce_n, 1);
                check("rst_mid_rd_rvalid", s_axi_rvalid, 0);
                @(posedge clk); #1 reset = 1'b0;
            end
        join
        do_read(4'h5, rd_r, lat_r, rc_r);
        check("rd_after_reset", rd_r, 8'h5C);
        check("rd_after_reset_latency", lat_r, RW + 1);

`ifdef SRAM_AXI_SLAVE_STATS_EN
        @(negedge clk);
        check("stat_wr_count", stat_wr_count, 16'(b_hs));
        check("stat_rd_count", stat_rd_count, 16'(r_hs));
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
